bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_sequencer.sv | 129 ++++++++++++
 tb/tb_bus_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Register-to-register transfer sequencer for a shared tri-state data bus.
// Each accepted request runs DRIVE -> WRITE -> TURN, with one turnaround cycle before the next request.
module bus_sequencer #(
  parameter int unsigned N = 16,
  parameter int unsigned R = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_src,
  input  logic [3:0]   req_dst,
  input  logic         req_imm_en,
  input  logic [N-1:0] req_imm,
  output logic [R-1:0] reg_read,
  output logic [R-1:0] reg_write,
  inout  wire  [N-1:0] data,
  output logic [N-1:0] xfer_data,
  output logic         done,
  output logic         err
);

  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  dst_q, dst_d;
  logic [N-1:0]   imm_q, imm_d;
  logic           drive_q, drive_d;
  logic           ready_q, ready_d;
  logic [R-1:0]   read_q, read_d;
  logic [R-1:0]   write_q, write_d;
  logic [N-1:0]   xfer_q, xfer_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           req_bad;

  // A register source is range-checked only when no immediate is selected
  assign req_bad = (32'(req_dst) >= R) || (!req_imm_en && (32'(req_src) >= R));

  // Outputs are registered: next values are computed alongside the next state
  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    xfer_d  = xfer_q;
    drive_d = 1'b0;
    ready_d = 1'b0;
    read_d  = '0;
    write_d = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            ready_d = 1'b0;
            state_d = DRIVE;
            dst_d   = req_dst;
            imm_d   = req_imm;
            if (req_imm_en) drive_d = 1'b1;
            else            read_d  = R'(1) << req_src;
          end
        end
      end
      DRIVE: begin
        state_d = WRITE;
        drive_d = drive_q;
        read_d  = read_q;
        write_d = R'(1) << dst_q;
      end
      WRITE: begin
        state_d = TURN;
        xfer_d  = data;
        done_d  = 1'b1;
      end
      TURN: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dst_q   <= '0;
      imm_q   <= '0;
      drive_q <= 1'b0;
      ready_q <= 1'b1;
      read_q  <= '0;
      write_q <= '0;
      xfer_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      drive_q <= drive_d;
      ready_q <= ready_d;
      read_q  <= read_d;
      write_q <= write_d;
      xfer_q  <= xfer_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // drive_q and read_q are never set together, so the bus has a single driver
  assign data      = drive_q ? imm_q : 'z;
  assign req_ready = ready_q;
  assign reg_read  = read_q;
  assign reg_write = write_q;
  assign xfer_data = xfer_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer (R=8) with a behavioural register file on the shared bus.
module tb_bus_sequencer;

  localparam int unsigned N = 16;
  localparam int unsigned R = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_src;
  logic [3:0]   req_dst;
  logic         req_imm_en;
  logic [N-1:0] req_imm;
  logic [R-1:0] reg_read;
  logic [R-1:0] reg_write;
  wire  [N-1:0] data;
  logic [N-1:0] xfer_data;
  logic         done;
  logic         err;

  int total = 0;
  int bad = 0;

  bus_sequencer #(.N(N), .R(R)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst),
    .req_imm_en(req_imm_en), .req_imm(req_imm),
    .reg_read(reg_read), .reg_write(reg_write),
    .data(data), .xfer_data(xfer_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Register file: drives the bus on reg_read, captures it on reg_write
  logic [N-1:0] regs [R];
  logic         load_en = 1'b0;
  logic [2:0]   load_idx = '0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] rf_val;

  always_comb begin
    rf_val = '0;
    for (int i = 0; i < R; i++) if (reg_read[i]) rf_val = regs[i];
  end
  assign data = (|reg_read) ? rf_val : 'z;

  always @(posedge clk) begin
    if (load_en) regs[load_idx] <= load_val;
    for (int i = 0; i < R; i++) if (reg_write[i]) regs[i] <= data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [N-1:0] val);
    load_en  = 1'b1;
    load_idx = 3'(idx);
    load_val = val;
    step();
    load_en  = 1'b0;
  endtask

  task automatic set_req(input logic imm_en, input logic [N-1:0] imm, input int src, input int dst);
    req_imm_en = imm_en;
    req_imm    = imm;
    req_src    = 4'(src);
    req_dst    = 4'(dst);
  endtask

  // One full transfer from handshake to the next ready cycle
  task automatic do_xfer(input string tag, input logic imm_en, input logic [N-1:0] imm,
                         input int src, input int dst, input logic [N-1:0] val);
    logic [R-1:0] rd_exp;
    rd_exp = imm_en ? R'(0) : (R'(1) << src);
    chk({tag, "_ready0"}, 32'(req_ready), 32'd1);
    set_req(imm_en, imm, src, dst);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk({tag, "_c1_read"},  32'(reg_read),  32'(rd_exp));
    chk({tag, "_c1_write"}, 32'(reg_write), 32'd0);
    chk({tag, "_c1_data"},  32'(data),      32'(val));
    chk({tag, "_c1_ready"}, 32'(req_ready), 32'd0);
    step();
    chk({tag, "_c2_read"},  32'(reg_read),  32'(rd_exp));
    chk({tag, "_c2_write"}, 32'(reg_write), 32'(R'(1) << dst));
    chk({tag, "_c2_data"},  32'(data),      32'(val));
    chk({tag, "_c2_done"},  32'(done),      32'd0);
    step();
    chk({tag, "_c3_done"},  32'(done),      32'd1);
    chk({tag, "_c3_strb"},  32'({reg_read, reg_write}), 32'd0);
    chk({tag, "_c3_xfer"},  32'(xfer_data), 32'(val));
    chk({tag, "_c3_reg"},   32'(regs[dst]), 32'(val));
    step();
    chk({tag, "_c4_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_c4_done"},  32'(done),      32'd0);
  endtask

  task automatic do_reject(input string tag, input logic imm_en, input int src, input int dst);
    set_req(imm_en, 16'h5555, src, dst);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk({tag, "_err"},   32'(err),       32'd1);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_strb"},  32'({reg_read, reg_write}), 32'd0);
    step();
    chk({tag, "_err_off"}, 32'(err),  32'd0);
    chk({tag, "_strb2"},   32'({reg_read, reg_write}), 32'd0);
    chk({tag, "_done"},    32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    set_req(1'b0, '0, 0, 0);
    #12;
    chk("rst_read",  32'(reg_read),  32'd0);
    chk("rst_write", 32'(reg_write), 32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_xfer",  32'(xfer_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rst_ready", 32'(req_ready), 32'd1);

    preload(3, 16'h1234);
    preload(5, 16'h00FF);
    preload(7, 16'h0000);
    preload(4, 16'h0BAD);
    preload(0, 16'h0000);

    do_xfer("copy", 1'b0, 16'h0000, 3, 7, 16'h1234);
    do_xfer("imm",  1'b1, 16'hBEEF, 0, 0, 16'hBEEF);
    do_xfer("self", 1'b0, 16'h0000, 5, 5, 16'h00FF);
    chk("self_keep", 32'(regs[5]), 32'h00FF);

    // Back-to-back: valid held, fields changed mid-transfer are ignored
    set_req(1'b0, 16'h0000, 7, 2);
    req_valid = 1'b1;
    step();
    set_req(1'b1, 16'hA5A5, 1, 6);
    for (int c = 1; c <= 3; c++) begin
      chk("b2b_a_read",  32'(reg_read),  c < 3 ? 32'(R'(1) << 7) : 32'd0);
      chk("b2b_a_ready", 32'(req_ready), 32'd0);
      step();
    end
    chk("b2b_ready_c4", 32'(req_ready), 32'd1);
    chk("b2b_a_reg",    32'(regs[2]),   32'h1234);
    step();
    req_valid = 1'b0;
    chk("b2b_b_read",  32'(reg_read), 32'd0);
    chk("b2b_b_data",  32'(data),     32'hA5A5);
    step();
    chk("b2b_b_read2", 32'(reg_read),  32'd0);
    chk("b2b_b_write", 32'(reg_write), 32'(R'(1) << 6));
    step();
    chk("b2b_b_done",  32'(done),    32'd1);
    chk("b2b_b_reg",   32'(regs[6]), 32'hA5A5);
    chk("b2b_b_xfer",  32'(xfer_data), 32'hA5A5);
    step();

    do_reject("dst9",  1'b0, 1, 9);
    do_reject("src12", 1'b0, 12, 1);
    do_reject("dst8",  1'b1, 0, 8);
    do_xfer("imm_src_ign", 1'b1, 16'h7E57, 12, 1, 16'h7E57);

    // Reset during WRITE: strobes drop at once, no write, no done
    set_req(1'b0, 16'h0000, 5, 4);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("abort_in_write", 32'(reg_write), 32'(R'(1) << 4));
    #2;
    rst = 1'b0;
    #1;
    chk("abort_read",  32'(reg_read),  32'd0);
    chk("abort_write", 32'(reg_write), 32'd0);
    chk("abort_done",  32'(done),      32'd0);
    step();
    chk("abort_reg",   32'(regs[4]),   32'h0BAD);
    chk("abort_done2", 32'(done),      32'd0);
    chk("abort_xfer",  32'(xfer_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_done3", 32'(done),      32'd0);
    chk("abort_reg2",  32'(regs[4]),   32'h0BAD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
